ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the multi-cycle RV32I core. Sits between ID and MA; the core
//  sequencer pulses e_i once per instruction.
//  - Computes the ALU/link result, the load/store effective address and the
//    PC-relative next-instruction offset.
//  - Passes op/sel/regd through for MA and writeback.
// PARAMETERS
//  none (datapath fixed at 32 bits, register index 5 bits)
// PORTS
//  clk      in   1   core clock, all state on rising edge
//  rst      in   1   reset, asynchronous, active-low
//  rdy      in   1   global ready; low = hold all state
//  e_i      in   1   enable: capture inputs and compute this cycle
//  op_i     in   5   opcode inst[6:2]
//  sel_i    in   3   funct3
//  reg1d_i  in  32   rs1 value
//  reg2d_i  in  32   rs2 value
//  pc_i     in  32   address of this instruction
//  imm_i    in  32   sign-extended immediate; for OP, imm_i[10] = inst[30]
//  regd_i   in   5   rd index (ID supplies 0 for branch/store)
//  op_o     out  5   registered op_i
//  regd_o   out  5   registered regd_i
//  sel_o    out  3   registered sel_i
//  res_o    out 32   result: ALU value / link / branch flag / store data
//  addr_o   out 32   memory effective address
//  jump_o   out 32   next PC minus pc_i; 32'd4 = fall-through
// BEHAVIOUR
//  - Reset (rst=0, async): every output clears to 0.
//  - Edge with rdy=1 and e_i=1: all outputs load from a combinational function of
//    the inputs. Latency 1 cycle. Outputs hold until the next enabled edge.
//  - rdy=0 or e_i=0: hold. rdy=0 overrides e_i.
//  - Defaults: addr_o=0 and jump_o=4, unless a row below sets them.
//  - Op decode table:
//    00000 LOAD : addr=rs1+imm, res=0
//    01000 STORE: addr=rs1+imm, res=rs2
//    01101 LUI  : res=imm
//    00101 AUIPC: res=pc+imm
//    11011 JAL  : res=pc+4, jump=imm
//    11001 JALR : res=pc+4, jump=((rs1+imm)&~1)-pc
//    11000 BRANCH: res=cond?1:0, jump=cond?imm:4
//      cond: 000 eq, 001 ne, 100 lt signed, 101 ge signed,
//            110 ltu, 111 geu; funct3 010/011 give cond=0
//    00100 OP-IMM: b = imm;  01100 OP: b = rs2
//  - ALU (shared by OP and OP-IMM, a = rs1):
//    000 add (sub if OP and imm[10])
//    001 sll
//    010 slt
//    011 sltu
//    100 xor
//    101 srl (sra if imm[10])
//    110 or
//    111 and
//    Shift amount = b[4:0]. slt/sltu give 0/1 in bit 0.
//  - Arithmetic is 32-bit modulo 2^32 with no overflow flag. Examples:
//    add 0x7FFFFFFF+1 = 0x80000000; pc+4 wraps at 2^32.
//  - Any other op: res=0, addr=0, jump=4 (treated as NOP).
//  - Sequencer contract: a non-jump is recognised by res_o==0 || jump_o==4, so
//    every non-control op must drive jump_o=4.
// STRUCTURE
//  - Shared package: 5-bit opcode constants (OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
//    OP_JAL, OP_JALR, OP_BRANCH, OP_OPIMM, OP_OP) and funct3 constants for the
//    ALU and branch selects. IF/ID/MA use the same package.
//  - One combinational sub-module ex_alu: (a, b, sel, alt) -> y. Branch compare
//    and address adders stay in ex_stage, followed by one output register bank.
// TESTING
//  1. Async reset: rst low mid-cycle (no clock edge needed)
//     -> all outputs 0 immediately; they stay 0 until an enabled edge.
//  2. OP sub: rs1=5, rs2=7, imm[10]=1, sel=000, e_i=1
//     -> next cycle res_o=0xFFFFFFFE, jump_o=4.
//     Then sra: rs1=0x80000000, rs2=4 -> res_o=0xF8000000.
//  3. BLT: rs1=0xFFFFFFFF, rs2=1, imm=0xFFFFFFF0 -> res_o=1, jump_o=0xFFFFFFF0.
//     Same with BLTU -> res_o=0, jump_o=4.
//  4. JALR: pc=0x100, rs1=0x203, imm=0, regd=1
//     -> res_o=0x104, jump_o=0x102, regd_o=1.
//     JAL imm=8 -> jump_o=8.
//  5. STORE: rs1=0x1000, imm=0xFFFFFFFC, rs2=0xAB, sel=010
//     -> addr_o=0xFFC, res_o=0xAB, op_o=01000, sel_o=010.
//  6. Hold: e_i=1 with rdy=0 -> outputs unchanged.
//     e_i=0 with new inputs -> outputs unchanged.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared RV32I decode constants and the execute-stage output record.
// IF/ID/MA import the same package so opcode and funct3 values stay in one place.
package ex_stage_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;

  // ALU funct3 selects
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // Branch funct3 selects (010/011 are not branches and never take)
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Fall-through offset; the sequencer reads jump == 4 as "not a jump"
  localparam logic [XLEN-1:0] JUMP_NEXT = 32'd4;

  // Everything the stage hands to MA/writeback
  typedef struct packed {
    logic [4:0]      op;
    logic [REGW-1:0] regd;
    logic [2:0]      sel;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] jump;
  } ex_out_t;

  // Branch condition on rs1/rs2
  function automatic logic branch_cond(input logic [2:0] sel,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic c;
    c = 1'b0;
    case (sel)
      BR_EQ:   c = (a == b);
      BR_NE:   c = (a != b);
      BR_LT:   c = ($signed(a) < $signed(b));
      BR_GE:   c = ($signed(a) >= $signed(b));
      BR_LTU:  c = (a < b);
      BR_GEU:  c = (a >= b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU shared by OP and OP-IMM.
// alt selects sub for add and sra for the right shift; the caller decides when
// alt is meaningful for add (only register-register OP may subtract).
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      sel,
  input  logic            alt,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Select one ALU function from funct3
  always_comb begin
    y = '0;
    case (sel)
      ALU_ADD:  y = alt ? (a - b) : (a + b);
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {31'b0, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SR:   y = alt ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the multi-cycle RV32I core.
// Capture contract: state loads on a rising edge only when rdy=1 and e_i=1;
// rdy=0 holds everything regardless of e_i, e_i=0 also holds. Result is
// visible one cycle after the enabled edge and stays until the next one.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            e_i,
  input  logic [4:0]      op_i,
  input  logic [2:0]      sel_i,
  input  logic [XLEN-1:0] reg1d_i,
  input  logic [XLEN-1:0] reg2d_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [REGW-1:0] regd_i,
  output logic [4:0]      op_o,
  output logic [REGW-1:0] regd_o,
  output logic [2:0]      sel_o,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] jump_o
);

  ex_out_t         nxt;
  ex_out_t         cur;
  logic [XLEN-1:0] alu_b;
  logic            alu_alt;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] jalr_tgt;
  logic            cond;

  // OP uses rs2; OP-IMM uses the immediate. imm[10] only means "sub" for OP.
  assign alu_b   = (op_i == OP_OP) ? reg2d_i : imm_i;
  assign alu_alt = imm_i[10] & ((sel_i != ALU_ADD) | (op_i == OP_OP));

  ex_alu u_alu (
    .a   (reg1d_i),
    .b   (alu_b),
    .sel (sel_i),
    .alt (alu_alt),
    .y   (alu_y)
  );

  assign ea       = reg1d_i + imm_i;
  assign link     = pc_i + 32'd4;
  assign jalr_tgt = ea & ~32'd1;
  assign cond     = branch_cond(sel_i, reg1d_i, reg2d_i);

  // Decode the opcode into the next output record; unknown ops act as NOP
  always_comb begin
    nxt      = '0;
    nxt.op   = op_i;
    nxt.regd = regd_i;
    nxt.sel  = sel_i;
    nxt.jump = JUMP_NEXT;
    case (op_i)
      OP_LOAD:   nxt.addr = ea;
      OP_STORE: begin
        nxt.addr = ea;
        nxt.res  = reg2d_i;
      end
      OP_LUI:    nxt.res = imm_i;
      OP_AUIPC:  nxt.res = pc_i + imm_i;
      OP_JAL: begin
        nxt.res  = link;
        nxt.jump = imm_i;
      end
      OP_JALR: begin
        nxt.res  = link;
        nxt.jump = jalr_tgt - pc_i;
      end
      OP_BRANCH: begin
        nxt.res  = {31'b0, cond};
        nxt.jump = cond ? imm_i : JUMP_NEXT;
      end
      OP_OPIMM,
      OP_OP:     nxt.res = alu_y;
      default:   nxt.res = '0;
    endcase
  end

  // Output register bank: async clear, load only on an enabled, ready edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= '0;
    end else if (rdy && e_i) begin
      cur <= nxt;
    end
  end

  assign op_o   = cur.op;
  assign regd_o = cur.regd;
  assign sel_o  = cur.sel;
  assign res_o  = cur.res;
  assign addr_o = cur.addr;
  assign jump_o = cur.jump;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a table of hand-computed vectors plus
// sequences for reset, hold and latency behaviour.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        e_i;
  logic [4:0]  op_i;
  logic [2:0]  sel_i;
  logic [31:0] reg1d_i;
  logic [31:0] reg2d_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic [4:0]  regd_i;
  logic [4:0]  op_o;
  logic [4:0]  regd_o;
  logic [2:0]  sel_o;
  logic [31:0] res_o;
  logic [31:0] addr_o;
  logic [31:0] jump_o;

  int n_checks;
  int n_errors;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [2:0]  sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  regd;
    logic [31:0] exp_res;
    logic [31:0] exp_addr;
    logic [31:0] exp_jump;
  } vec_t;

  vec_t vecs[$];

  ex_stage dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .e_i     (e_i),
    .op_i    (op_i),
    .sel_i   (sel_i),
    .reg1d_i (reg1d_i),
    .reg2d_i (reg2d_i),
    .pc_i    (pc_i),
    .imm_i   (imm_i),
    .regd_i  (regd_i),
    .op_o    (op_o),
    .regd_o  (regd_o),
    .sel_o   (sel_o),
    .res_o   (res_o),
    .addr_o  (addr_o),
    .jump_o  (jump_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [4:0] op, input logic [2:0] sel,
                           input logic [4:0] regd, input logic [31:0] res,
                           input logic [31:0] addr, input logic [31:0] jump);
    check({name, ".op"},   {27'b0, op_o},   {27'b0, op});
    check({name, ".sel"},  {29'b0, sel_o},  {29'b0, sel});
    check({name, ".regd"}, {27'b0, regd_o}, {27'b0, regd});
    check({name, ".res"},  res_o,  res);
    check({name, ".addr"}, addr_o, addr);
    check({name, ".jump"}, jump_o, jump);
  endtask

  function automatic vec_t mk(input string name, input logic [4:0] op, input logic [2:0] sel,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] regd, input logic [31:0] res,
                              input logic [31:0] addr, input logic [31:0] jump);
    vec_t v;
    v.name = name; v.op = op; v.sel = sel; v.rs1 = rs1; v.rs2 = rs2;
    v.pc = pc; v.imm = imm; v.regd = regd;
    v.exp_res = res; v.exp_addr = addr; v.exp_jump = jump;
    return v;
  endfunction

  // Drive one vector on the falling edge, with the given rdy/e_i
  task automatic drive(input vec_t v, input logic r, input logic e);
    @(negedge clk);
    op_i = v.op; sel_i = v.sel; reg1d_i = v.rs1; reg2d_i = v.rs2;
    pc_i = v.pc; imm_i = v.imm; regd_i = v.regd;
    rdy = r; e_i = e;
  endtask

  task automatic apply_and_check(input vec_t v);
    drive(v, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_all(v.name, v.op, v.sel, v.regd, v.exp_res, v.exp_addr, v.exp_jump);
  endtask

  initial begin
    vec_t v_jalr;
    vec_t v_store;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; rdy = 1'b1; e_i = 1'b0;
    op_i = '0; sel_i = '0; reg1d_i = '0; reg2d_i = '0;
    pc_i = '0; imm_i = '0; regd_i = '0;

    // Reset state
    #2;
    check_all("reset", 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all("idle_after_reset", 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);

    //            name        op        sel     rs1           rs2           pc            imm           rd   res           addr          jump
    vecs.push_back(mk("op_sub",   5'b01100, 3'b000, 32'd5,        32'd7,        32'h0,        32'h400,      5'd3, 32'hFFFFFFFE, 32'h0,        32'd4));
    vecs.push_back(mk("op_sra",   5'b01100, 3'b101, 32'h80000000, 32'd4,        32'h0,        32'h400,      5'd3, 32'hF8000000, 32'h0,        32'd4));
    vecs.push_back(mk("op_srl",   5'b01100, 3'b101, 32'h80000000, 32'd4,        32'h0,        32'h0,        5'd3, 32'h08000000, 32'h0,        32'd4));
    vecs.push_back(mk("addi_wrap",5'b00100, 3'b000, 32'h7FFFFFFF, 32'h0,        32'h0,        32'd1,        5'd4, 32'h80000000, 32'h0,        32'd4));
    vecs.push_back(mk("addi_neg", 5'b00100, 3'b000, 32'd1,        32'h0,        32'h0,        32'hFFFFFC00, 5'd4, 32'hFFFFFC01, 32'h0,        32'd4));
    vecs.push_back(mk("slli",     5'b00100, 3'b001, 32'd1,        32'h0,        32'h0,        32'd31,       5'd5, 32'h80000000, 32'h0,        32'd4));
    vecs.push_back(mk("slt",      5'b01100, 3'b010, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        5'd6, 32'd1,        32'h0,        32'd4));
    vecs.push_back(mk("sltu",     5'b01100, 3'b011, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        5'd6, 32'd0,        32'h0,        32'd4));
    vecs.push_back(mk("xor",      5'b01100, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        5'd7, 32'h0FF00FF0, 32'h0,        32'd4));
    vecs.push_back(mk("or",       5'b01100, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        5'd7, 32'hFFF0FFF0, 32'h0,        32'd4));
    vecs.push_back(mk("and",      5'b01100, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        5'd7, 32'hF000F000, 32'h0,        32'd4));
    vecs.push_back(mk("blt",      5'b11000, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h40,       32'hFFFFFFF0, 5'd0, 32'd1,        32'h0,        32'hFFFFFFF0));
    vecs.push_back(mk("bltu",     5'b11000, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h40,       32'hFFFFFFF0, 5'd0, 32'd0,        32'h0,        32'd4));
    vecs.push_back(mk("beq",      5'b11000, 3'b000, 32'd5,        32'd5,        32'h40,       32'h20,       5'd0, 32'd1,        32'h0,        32'h20));
    vecs.push_back(mk("bne",      5'b11000, 3'b001, 32'd5,        32'd5,        32'h40,       32'h20,       5'd0, 32'd0,        32'h0,        32'd4));
    vecs.push_back(mk("bge",      5'b11000, 3'b101, 32'd1,        32'hFFFFFFFF, 32'h40,       32'h20,       5'd0, 32'd1,        32'h0,        32'h20));
    vecs.push_back(mk("bgeu",     5'b11000, 3'b111, 32'd1,        32'hFFFFFFFF, 32'h40,       32'h20,       5'd0, 32'd0,        32'h0,        32'd4));
    vecs.push_back(mk("br_f3_010",5'b11000, 3'b010, 32'd5,        32'd5,        32'h40,       32'h20,       5'd0, 32'd0,        32'h0,        32'd4));
    vecs.push_back(mk("jal_wrap", 5'b11011, 3'b000, 32'h0,        32'h0,        32'hFFFFFFFC, 32'd8,        5'd1, 32'h0,        32'h0,        32'd8));
    vecs.push_back(mk("load",     5'b00000, 3'b010, 32'h10,       32'h0,        32'h0,        32'd4,        5'd9, 32'h0,        32'h14,       32'd4));
    vecs.push_back(mk("lui",      5'b01101, 3'b000, 32'h0,        32'h0,        32'h0,        32'h12345000, 5'd2, 32'h12345000, 32'h0,        32'd4));
    vecs.push_back(mk("auipc",    5'b00101, 3'b000, 32'h0,        32'h0,        32'h1000,     32'h2000,     5'd2, 32'h3000,     32'h0,        32'd4));
    vecs.push_back(mk("nop_op",   5'b11111, 3'b000, 32'h55,       32'h66,       32'h100,      32'h77,       5'd8, 32'h0,        32'h0,        32'd4));

    foreach (vecs[i]) apply_and_check(vecs[i]);

    v_jalr  = mk("jalr",  5'b11001, 3'b000, 32'h203,  32'h0,  32'h100, 32'h0,        5'd1, 32'h104, 32'h0,   32'h102);
    v_store = mk("store", 5'b01000, 3'b010, 32'h1000, 32'hAB, 32'h0,   32'hFFFFFFFC, 5'd0, 32'hAB,  32'hFFC, 32'd4);

    // JALR loads, then rdy=0 blocks a new capture even with e_i=1
    apply_and_check(v_jalr);
    drive(v_store, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_all("hold_rdy0", v_jalr.op, v_jalr.sel, v_jalr.regd, v_jalr.exp_res, v_jalr.exp_addr, v_jalr.exp_jump);
    // e_i=0 also holds
    drive(v_store, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_all("hold_e0", v_jalr.op, v_jalr.sel, v_jalr.regd, v_jalr.exp_res, v_jalr.exp_addr, v_jalr.exp_jump);
    // Enabled edge picks up the store
    apply_and_check(v_store);
    @(negedge clk) e_i = 1'b0;

    // Async reset mid-cycle, no edge between assert and check
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_all("async_reset", 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all("post_reset_hold", 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
